// File: rtl/dsp_hdlc_rx_ctrl.sv
// HDLC receive buffer controller: captures frames, DSP reads over EMIF.
// Optional RX_CRC_STRIP_EN: reported len excludes the 2 FCS bytes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rx_dv/sof/eof       byte valid, first byte, frame end
//   rx_crc_err/abort    FCS error (with eof), abort sequence
//   rx_data[7:0]        received byte
//   emif_dpram_wen/ren  EMIF strobes (pre-synchronised)
//   emif_dpram_addr     EMIF word address
//   emif_data           EMIF write data (strobe qualifier only)
//   emif_rdata[15:0]    registered read data
//   rx_int              frame-ready pulse to DSP
module dsp_hdlc_rx_ctrl #(
  parameter int unsigned MAX_LEN        = 240,
  parameter logic [23:0] ADDR_RX_DROP   = 24'd252,
  parameter logic [23:0] ADDR_RX_ACK    = 24'd253,
  parameter logic [23:0] ADDR_RX_STATUS = 24'd254,
  parameter logic [9:0]  INT_WIDTH      = 10'd84
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic        rx_sof,
  input  logic        rx_eof,
  input  logic        rx_crc_err,
  input  logic        rx_abort,
  input  logic [7:0]  rx_data,
  input  logic        emif_dpram_wen,
  input  logic        emif_dpram_ren,
  input  logic [23:0] emif_dpram_addr,
  input  logic [15:0] emif_data,
  output logic [15:0] emif_rdata,
  output logic        rx_int
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0]  PTR_MAX  = 8'(MAX_LEN);
  localparam logic [23:0] ADDR_MAX = 24'(MAX_LEN);

  logic [7:0] mem [MAX_LEN];

  logic [1:0] state, state_nx;
  logic [7:0] wr_ptr, ptr_nx;
  logic [9:0] len, len_nx;
  logic [9:0] frame_len;
  logic       valid, valid_nx;
  logic       crc_err, crc_nx;
  logic       ovf, ovf_nx;
  logic [7:0] drop_cnt;
  logic [9:0] int_cnt;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic       done_entry;

  logic sof_byte, full, ack, ack_done;
  logic drop_inc, drop_rd;
  logic unused_emif;

  assign unused_emif = ^emif_data;

  assign sof_byte = rx_dv && rx_sof;
  assign full     = (wr_ptr == PTR_MAX);
  assign ack      = emif_dpram_wen &&
                    (emif_dpram_addr == ADDR_RX_ACK);
  assign ack_done = ack && (state == S_DONE);
  assign drop_inc = (state == S_DONE) && rx_eof;
  assign drop_rd  = emif_dpram_ren &&
                    (emif_dpram_addr == ADDR_RX_DROP);

  always_comb begin
    state_nx   = state;
    ptr_nx     = wr_ptr;
    len_nx     = len;
    valid_nx   = valid;
    crc_nx     = crc_err;
    ovf_nx     = ovf;
    wr_en      = 1'b0;
    wr_addr    = wr_ptr;
    done_entry = 1'b0;
    frame_len  = '0;
    unique case (state)
      S_IDLE: begin
        if (sof_byte && !rx_abort) begin
          wr_en      = 1'b1;
          wr_addr    = '0;
          ptr_nx     = 8'd1;
          ovf_nx     = 1'b0;
          state_nx   = S_RECV;
          done_entry = rx_eof;
        end
      end
      S_RECV: begin
        if (rx_abort) begin
          ptr_nx   = '0;
          state_nx = S_IDLE;
        end else begin
          if (sof_byte) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            ptr_nx  = 8'd1;
            ovf_nx  = 1'b0;
          end else if (rx_dv) begin
            if (full) begin
              ovf_nx = 1'b1;
            end else begin
              wr_en  = 1'b1;
              ptr_nx = wr_ptr + 8'd1;
            end
          end
          done_entry = rx_eof;
        end
      end
      S_DONE: begin
        if (ack) begin
          valid_nx = 1'b0;
          ptr_nx   = '0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
`ifdef RX_CRC_STRIP_EN
    if (ptr_nx >= 8'd2)
      frame_len = {2'b00, ptr_nx - 8'd2};
    else
      frame_len = '0;
`else
    frame_len = {2'b00, ptr_nx};
`endif
    if (done_entry) begin
      len_nx   = frame_len;
      valid_nx = 1'b1;
      crc_nx   = rx_crc_err;
      state_nx = S_DONE;
    end
  end

  // Buffer survives reset; only the write is held off.
  always_ff @(posedge clk) begin
    if (wr_en && !rst)
      mem[wr_addr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      len        <= '0;
      valid      <= 1'b0;
      crc_err    <= 1'b0;
      ovf        <= 1'b0;
      drop_cnt   <= '0;
      int_cnt    <= '0;
      rx_int     <= 1'b0;
      emif_rdata <= '0;
    end else begin
      state   <= state_nx;
      wr_ptr  <= ptr_nx;
      len     <= len_nx;
      valid   <= valid_nx;
      crc_err <= crc_nx;
      ovf     <= ovf_nx;

      // Read-clear wins, but a drop in the same cycle survives as 1.
      if (drop_rd)
        drop_cnt <= {7'd0, drop_inc};
      else if (drop_inc && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;

      // rx_int follows the counter one cycle late.
      if (ack_done) begin
        int_cnt <= '0;
        rx_int  <= 1'b0;
      end else begin
        rx_int <= (int_cnt != '0);
        if (done_entry)
          int_cnt <= INT_WIDTH;
        else if (int_cnt != '0)
          int_cnt <= int_cnt - 10'd1;
      end

      if (emif_dpram_ren) begin
        unique case (1'b1)
          (emif_dpram_addr < ADDR_MAX):
            emif_rdata <= {8'h00, mem[emif_dpram_addr[7:0]]};
          (emif_dpram_addr == ADDR_RX_STATUS):
            emif_rdata <= {valid, crc_err, ovf, 3'b000, len};
          (emif_dpram_addr == ADDR_RX_DROP):
            emif_rdata <= {8'h00, drop_cnt};
          default:
            emif_rdata <= 16'h0000;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsp_hdlc_rx_ctrl.sv
// Bench for dsp_hdlc_rx_ctrl: frame-level model plus directed cases.
// Random phase drives all inputs; outputs compared every cycle.
module tb_dsp_hdlc_rx_ctrl;

  localparam int ML = 240;
  localparam logic [23:0] A_DROP = 24'd252;
  localparam logic [23:0] A_ACK  = 24'd253;
  localparam logic [23:0] A_STAT = 24'd254;
`ifdef RX_CRC_STRIP_EN
  localparam int STRIP = 1;
`else
  localparam int STRIP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv, rx_sof, rx_eof;
  logic        rx_crc_err, rx_abort;
  logic [7:0]  rx_data;
  logic        emif_dpram_wen, emif_dpram_ren;
  logic [23:0] emif_dpram_addr;
  logic [15:0] emif_data;
  logic [15:0] emif_rdata;
  logic        rx_int;

  always #5 clk = ~clk;

  dsp_hdlc_rx_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .rx_dv           (rx_dv),
    .rx_sof          (rx_sof),
    .rx_eof          (rx_eof),
    .rx_crc_err      (rx_crc_err),
    .rx_abort        (rx_abort),
    .rx_data         (rx_data),
    .emif_dpram_wen  (emif_dpram_wen),
    .emif_dpram_ren  (emif_dpram_ren),
    .emif_dpram_addr (emif_dpram_addr),
    .emif_data       (emif_data),
    .emif_rdata      (emif_rdata),
    .rx_int          (rx_int)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference: bytes of the current frame in a queue.
  int         m_mode;
  int         q[$];
  logic [7:0] mbuf [256];
  bit         mknown [256];
  int         m_len, m_drop;
  bit         m_valid, m_crc, m_ovf;
  logic [15:0] exp_rdata;
  bit         exp_rd_ok, exp_int;
  int         k = 0;
  int         done_edge = -1;
  int         int_end = -1;
  bit         chk_en = 0;

  task automatic check(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic int rep_len(input int n);
    int l;
    l = (n > ML) ? ML : n;
    if (STRIP != 0) l = (l >= 2) ? l - 2 : 0;
    return l;
  endfunction

  // Computes expected outputs after the coming posedge.
  task automatic model_step();
    int a;
    bit inc, ack;
    k++;
    chk_en = 1;
    if (rst) begin
      m_mode = 0; q.delete();
      m_len = 0; m_valid = 0; m_crc = 0; m_ovf = 0;
      m_drop = 0; exp_rdata = 0; exp_rd_ok = 1;
      int_end = -1; exp_int = 0;
      return;
    end
    a = int'(emif_dpram_addr);
    if (emif_dpram_ren) begin
      exp_rd_ok = 1;
      if (a < ML) begin
        if (mknown[a]) exp_rdata = {8'h00, mbuf[a]};
        else exp_rd_ok = 0;
      end else if (a == int'(A_STAT))
        exp_rdata = {m_valid, m_crc, m_ovf, 3'b000, 10'(m_len)};
      else if (a == int'(A_DROP))
        exp_rdata = 16'(m_drop);
      else
        exp_rdata = 16'h0000;
    end
    inc = (m_mode == 2) && rx_eof;
    if (emif_dpram_ren && a == int'(A_DROP)) m_drop = inc ? 1 : 0;
    else if (inc && m_drop < 255) m_drop++;
    ack = emif_dpram_wen && a == int'(A_ACK);
    if (m_mode == 2) begin
      if (ack) begin
        m_valid = 0; m_mode = 0;
        if (int_end > k - 1) int_end = k - 1;
      end
    end else if (m_mode == 1 && rx_abort) begin
      q.delete(); m_mode = 0;
    end else begin
      if (rx_dv && rx_sof && !rx_abort) begin
        q.delete(); q.push_back(rx_data);
        mbuf[0] = rx_data; mknown[0] = 1;
        m_ovf = 0; m_mode = 1;
      end else if (m_mode == 1 && rx_dv) begin
        q.push_back(rx_data);
        if (q.size() <= ML) begin
          mbuf[q.size()-1] = rx_data; mknown[q.size()-1] = 1;
        end else m_ovf = 1;
      end
      if (m_mode == 1 && rx_eof) begin
        m_len = rep_len(q.size());
        m_valid = 1; m_crc = rx_crc_err; m_mode = 2;
        done_edge = k; int_end = k + 84;
      end
    end
    exp_int = (k > done_edge) && (k <= int_end);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_int", {15'd0, rx_int}, {15'd0, exp_int});
      if (exp_rd_ok) check("emif_rdata", emif_rdata, exp_rdata);
    end
  end

  task automatic tick();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    rx_dv = 0; rx_sof = 0; rx_eof = 0;
    rx_crc_err = 0; rx_abort = 0; rx_data = 0;
    emif_dpram_wen = 0; emif_dpram_ren = 0;
    emif_dpram_addr = 0; emif_data = 0;
  endtask

  task automatic idle(input int n);
    clr();
    repeat (n) tick();
  endtask

  task automatic frame(input int n, input int base,
                       input bit crc, input bit eof_on = 1);
    for (int i = 0; i < n; i++) begin
      clr();
      rx_dv = 1; rx_sof = (i == 0);
      rx_eof = eof_on && (i == n - 1);
      rx_crc_err = crc; rx_data = 8'(base + i);
      tick();
    end
    clr();
  endtask

  task automatic rd(input int a, output logic [15:0] v);
    clr();
    emif_dpram_ren = 1; emif_dpram_addr = 24'(a);
    tick();
    clr();
    v = emif_rdata;
  endtask

  task automatic ack_wr();
    clr();
    emif_dpram_wen = 1; emif_dpram_addr = A_ACK;
    emif_data = 16'h0001;
    tick();
    clr();
  endtask

  logic [15:0] v;
  int cnt, w;

  initial begin
    clr();
    rst = 1;
    tick(); tick();
    rst = 0;
    check("reset_int", {15'd0, rx_int}, 16'd0);
    rd(A_STAT, v); check("reset_status", v, 16'h0000);
    rd(A_DROP, v); check("reset_drop", v, 16'h0000);

    // 5-byte frame, interrupt width and contents
    frame(5, 'h11, 0);
    cnt = 0;
    repeat (90) begin tick(); cnt += int'(rx_int); end
    check("t1_int_width", 16'(cnt), 16'd84);
    rd(A_STAT, v);
    check("t1_status", v, (STRIP != 0) ? 16'h8003 : 16'h8005);
    for (int i = 0; i < 5; i++) begin
      rd(i, v); check("t1_byte", v, 16'(8'h11 + i));
    end
    ack_wr();

    // overlong frame
    frame(245, 1, 0);
    rd(A_STAT, v);
    check("t2_status", v, (STRIP != 0) ? 16'hA0EE : 16'hA0F0);
    rd(239, v); check("t2_last_byte", v, 16'h00F0);
    ack_wr();

    // second frame while buffer is held
    frame(3, 'h21, 0);
    frame(4, 'h31, 0);
    rd(0, v); check("t3_buf_kept", v, 16'h0021);
    rd(A_DROP, v); check("t3_drop1", v, 16'h0001);
    rd(A_DROP, v); check("t3_drop_clr", v, 16'h0000);
    clr(); rx_eof = 1;
    emif_dpram_ren = 1; emif_dpram_addr = A_DROP;
    tick(); clr();
    check("t3_drop_race_old", emif_rdata, 16'h0000);
    rd(A_DROP, v); check("t3_drop_race_new", v, 16'h0001);
    ack_wr();

    // abort mid-frame
    frame(3, 'h41, 0, 0);
    clr(); rx_abort = 1; tick();
    idle(5);
    check("t4_no_int", {15'd0, rx_int}, 16'd0);
    rd(A_STAT, v);
    check("t4_idle_status", v, (STRIP != 0) ? 16'h0001 : 16'h0003);
    frame(2, 'h51, 0);
    rd(A_STAT, v);
    check("t4_status", v, (STRIP != 0) ? 16'h8000 : 16'h8002);
    ack_wr();

    // early ACK and CRC error
    frame(4, 'h61, 0);
    w = 0;
    clr();
    while (!rx_int && w < 5) begin tick(); w++; end
    check("t5_int_rise", {15'd0, rx_int}, 16'd1);
    repeat (9) tick();
    check("t5_int_held", {15'd0, rx_int}, 16'd1);
    ack_wr();
    check("t5_int_drop", {15'd0, rx_int}, 16'd0);
    rd(A_STAT, v);
    check("t5_valid_clr", v, (STRIP != 0) ? 16'h0002 : 16'h0004);
    frame(3, 'h71, 1);
    rd(A_STAT, v);
    check("t5_crc", v, (STRIP != 0) ? 16'hC001 : 16'hC003);
    ack_wr();

    // reset mid-frame
    frame(3, 'h81, 0, 0);
    clr(); rst = 1; tick(); rst = 0;
    check("t6_int", {15'd0, rx_int}, 16'd0);
    rd(A_STAT, v); check("t6_status", v, 16'h0000);
    rd(A_DROP, v); check("t6_drop", v, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      clr(); rx_dv = 1; rx_eof = (i == 2);
      rx_data = 8'(i); tick();
    end
    idle(3);
    rd(A_STAT, v); check("t6_no_sof", v, 16'h0000);

    // random traffic against the model
    repeat (6000) begin
      clr();
      rx_dv      = ($urandom_range(0, 1) == 1);
      rx_sof     = ($urandom_range(0, 19) == 0);
      rx_eof     = ($urandom_range(0, 24) == 0);
      rx_crc_err = ($urandom_range(0, 1) == 1);
      rx_abort   = ($urandom_range(0, 99) == 0);
      rx_data    = 8'($urandom);
      emif_dpram_ren = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0, 1, 2: emif_dpram_addr = 24'($urandom_range(0, 255));
        3:       emif_dpram_addr = A_DROP;
        4:       emif_dpram_addr = A_STAT;
        default: emif_dpram_addr = 24'($urandom);
      endcase
      if ($urandom_range(0, 29) == 0) begin
        emif_dpram_wen  = 1;
        emif_dpram_addr = A_ACK;
        emif_data       = 16'($urandom);
      end
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
